// File: rtl/csr_excp_unit_pkg.sv
// Shared CSR defines: addresses, field bit positions and exception code constants
// for the CSR / exception unit and its timer.
package csr_excp_unit_pkg;

  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00C;
  localparam logic [13:0] CSR_TLBEHI    = 14'h011;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

  localparam int CRMD_PLV_LO   = 0;
  localparam int CRMD_IE       = 2;
  localparam int CRMD_DA       = 3;
  localparam int CRMD_PG       = 4;
  localparam int PRMD_PPLV_LO  = 0;
  localparam int PRMD_PIE      = 2;
  localparam int ESTAT_ECODE_LO = 16;
  localparam int ESTAT_ESUB_LO  = 22;
  localparam int IS_TI         = 11;
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TICLR_CLR     = 0;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [8:0] ESUBCODE_NONE = 9'h000;

  // Timer start/reload value is InitVal scaled by four.
  function automatic logic [31:0] tcfg_reload(input logic [31:0] tcfg);
    return {tcfg[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: TCFG/TVAL registers and the timer interrupt status bit IS[11].
module csr_timer
  import csr_excp_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tcfg_we,
  input  logic [31:0] wdata,
  input  logic        ticlr_we,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        ti
);

  logic expire;

  assign expire = ~tcfg_we & tcfg[TCFG_EN] & (tval == 32'd1);

  // A TCFG write takes priority over counting; En=0 in the write freezes TVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcfg <= 32'd0;
      tval <= 32'd0;
    end else if (tcfg_we) begin
      tcfg <= wdata;
      if (wdata[TCFG_EN]) tval <= tcfg_reload(wdata);
    end else if (tcfg[TCFG_EN] && tval != 32'd0) begin
      if (tval == 32'd1) begin
        if (tcfg[TCFG_PERIODIC]) begin
          tval <= tcfg_reload(tcfg);
        end else begin
          tval          <= 32'd0;
          tcfg[TCFG_EN] <= 1'b0;
        end
      end else begin
        tval <= tval - 32'd1;
      end
    end
  end

  // Expiry beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)           ti <= 1'b0;
    else if (expire)   ti <= 1'b1;
    else if (ticlr_we) ti <= 1'b0;
  end

endmodule

// File: rtl/csr_excp_unit.sv
// CSR file with exception entry/return handling, interrupt pending detection
// and front-end redirect generation.
module csr_excp_unit
  import csr_excp_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] csr_era,
  input  logic [5:0]  csr_ecode,
  input  logic [8:0]  csr_esubcode,
  input  logic        va_error,
  input  logic [31:0] bad_va,
  input  logic        excp_tlbrefill,
  input  logic        excp_tlb,
  input  logic [18:0] excp_tlb_vppn,
  input  logic [7:0]  hw_int,
  input  logic        ipi,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        int_pending,
  output logic [1:0]  plv,
  output logic        da,
  output logic        pg
);

  logic [1:0]  crmd_plv;
  logic        crmd_ie, crmd_da, crmd_pg;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ipi;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era, badv;
  logic [25:0] eentry, tlbrentry;
  logic [18:0] tlbehi_vppn;
  logic [31:0] tcfg, tval;
  logic        ti;
  logic [12:0] estat_is;
  logic        wr_en;

  // Flushes of the committing instruction discard any same-cycle CSR write.
  assign wr_en    = csr_we & ~excp_flush & ~ertn_flush;
  assign estat_is = {is_ipi, ti, 1'b0, is_hw, is_sw};

  csr_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .tcfg_we  (wr_en && csr_waddr == CSR_TCFG),
    .wdata    (csr_wdata),
    .ticlr_we (wr_en && csr_waddr == CSR_TICLR && csr_wdata[TICLR_CLR]),
    .tcfg     (tcfg),
    .tval     (tval),
    .ti       (ti)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_plv  <= 2'd0;
      crmd_ie   <= 1'b0;
      crmd_da   <= 1'b1;
      crmd_pg   <= 1'b0;
      prmd_pplv <= 2'd0;
      prmd_pie  <= 1'b0;
    end else if (excp_flush) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
      crmd_plv  <= 2'd0;
      crmd_ie   <= 1'b0;
      if (excp_tlbrefill) begin
        crmd_da <= 1'b1;
        crmd_pg <= 1'b0;
      end
    end else if (ertn_flush) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
      if (estat_ecode == ECODE_TLBR) begin
        crmd_da <= 1'b0;
        crmd_pg <= 1'b1;
      end
    end else if (wr_en && csr_waddr == CSR_CRMD) begin
      crmd_plv <= csr_wdata[CRMD_PLV_LO +: 2];
      crmd_ie  <= csr_wdata[CRMD_IE];
      crmd_da  <= csr_wdata[CRMD_DA];
      crmd_pg  <= csr_wdata[CRMD_PG];
    end else if (wr_en && csr_waddr == CSR_PRMD) begin
      prmd_pplv <= csr_wdata[PRMD_PPLV_LO +: 2];
      prmd_pie  <= csr_wdata[PRMD_PIE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estat_ecode <= ECODE_INT;
      estat_esub  <= ESUBCODE_NONE;
      era         <= 32'd0;
      badv        <= 32'd0;
      tlbehi_vppn <= 19'd0;
    end else if (excp_flush) begin
      estat_ecode <= csr_ecode;
      estat_esub  <= csr_esubcode;
      era         <= csr_era;
      if (va_error) badv        <= bad_va;
      if (excp_tlb) tlbehi_vppn <= excp_tlb_vppn;
    end else if (wr_en) begin
      if (csr_waddr == CSR_ERA)    era         <= csr_wdata;
      if (csr_waddr == CSR_BADV)   badv        <= csr_wdata;
      if (csr_waddr == CSR_TLBEHI) tlbehi_vppn <= csr_wdata[31:13];
    end
  end

  // Hardware and IPI status bits track their lines every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ecfg_lie  <= 13'd0;
      is_sw     <= 2'd0;
      is_hw     <= 8'd0;
      is_ipi    <= 1'b0;
      eentry    <= 26'd0;
      tlbrentry <= 26'd0;
    end else begin
      is_hw  <= hw_int;
      is_ipi <= ipi;
      if (wr_en) begin
        if (csr_waddr == CSR_ECFG)      ecfg_lie  <= csr_wdata[12:0];
        if (csr_waddr == CSR_ESTAT)     is_sw     <= csr_wdata[1:0];
        if (csr_waddr == CSR_EENTRY)    eentry    <= csr_wdata[31:6];
        if (csr_waddr == CSR_TLBRENTRY) tlbrentry <= csr_wdata[31:6];
      end
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      CSR_CRMD:      csr_rdata = {27'd0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:      csr_rdata = {29'd0, prmd_pie, prmd_pplv};
      CSR_ECFG:      csr_rdata = {19'd0, ecfg_lie};
      CSR_ESTAT:     csr_rdata = {1'b0, estat_esub, estat_ecode, 3'd0, estat_is};
      CSR_ERA:       csr_rdata = era;
      CSR_BADV:      csr_rdata = badv;
      CSR_EENTRY:    csr_rdata = {eentry, 6'd0};
      CSR_TLBEHI:    csr_rdata = {tlbehi_vppn, 13'd0};
      CSR_TCFG:      csr_rdata = tcfg;
      CSR_TVAL:      csr_rdata = tval;
      CSR_TLBRENTRY: csr_rdata = {tlbrentry, 6'd0};
      default:       csr_rdata = 32'd0;
    endcase
  end

  // Redirect targets come from the register values before this cycle's update.
  always_comb begin
    redirect_pc = 32'd0;
    if (excp_flush)      redirect_pc = excp_tlbrefill ? {tlbrentry, 6'd0} : {eentry, 6'd0};
    else if (ertn_flush) redirect_pc = era;
  end

  assign redirect_valid = (excp_flush | ertn_flush) & ~rst;
  assign int_pending    = crmd_ie & (|(estat_is & ecfg_lie));
  assign plv            = crmd_plv;
  assign da             = crmd_da;
  assign pg             = crmd_pg;

endmodule
